// File: rtl/traffic_phase_scheduler_if.sv
// Sensor inputs and lamp/status outputs of the phase scheduler, bundled as one port.
// The master side is the scheduler (reads sensors, drives lamps); the slave side is the environment.
// Widths follow N_APPR; active_idx is at least one bit wide.
interface traffic_phase_scheduler_if #(
  parameter int N_APPR = 4
);
  localparam int AW = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  logic [N_APPR-1:0] S;
  logic [N_APPR-1:0] R;
  logic [N_APPR-1:0] Y;
  logic [N_APPR-1:0] G;
  logic [AW-1:0]     active_idx;
  logic [1:0]        phase;

  modport master (input S, output R, Y, G, active_idx, phase);
  modport slave  (output S, input R, Y, G, active_idx, phase);
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Round-robin right-of-way sequencer for N approaches with min/max green, yellow and all-red timers.
// Latency: sensor -> latched request in 1 cycle; all lamp/status outputs are registered.
// No backpressure: sensors are level inputs sampled every cycle, lamps always reflect the current phase.
module traffic_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 50,
  parameter int MAX_GREEN = 200,
  parameter int YELLOW_T  = 20,
  parameter int ALLRED_T  = 10,
  parameter int REST_APPR = 0,
  parameter int TW        = $clog2(MAX_GREEN + 1)
) (
  input logic                        clk,
  input logic                        reset,
  traffic_phase_scheduler_if.master  bus
);
  localparam int AW = (N_APPR > 1) ? $clog2(N_APPR) : 1;

  // Last timer value of each phase: a phase of length X exits when timer == X-1.
  localparam logic [TW-1:0] MIN_END = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_END = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_END = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_END  = TW'(ALLRED_T - 1);

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer;
  logic [N_APPR-1:0] wait_q, wait_nxt;
  logic [AW-1:0]     last, last_nxt;
  logic [AW-1:0]     pick;
  logic              pick_vld;
  logic [AW-1:0]     idx;
  logic              grant;
  logic              others;
  logic [N_APPR-1:0] cur_onehot;
  logic [N_APPR-1:0] nxt_onehot;
  logic [N_APPR-1:0] r_q, y_q, g_q;
  logic [N_APPR-1:0] y_nxt, g_nxt;

  assign cur_onehot = N_APPR'(1) << last;
  assign nxt_onehot = N_APPR'(1) << last_nxt;
  // wait_q of the green approach is never set, so masking it is just for clarity.
  assign others     = |(wait_q & ~cur_onehot);
  assign grant      = (state == ALL_RED) && (timer == AR_END);

  // Round-robin search starting just after the last granted approach; falls back to the rest approach.
  always_comb begin
    pick     = AW'(REST_APPR);
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_APPR; k++) begin
      idx = AW'((int'(last) + k) % N_APPR);
      if (!pick_vld && wait_q[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Phase sequencing: next state and next granted approach.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ALL_RED: begin
        if (timer == AR_END) begin
          state_nxt = GREEN;
          last_nxt  = pick;
        end
      end
      GREEN: begin
        // Leave only when someone waits, min green is served, and either the gap
        // appeared or max green is reached (>= covers a saturated timer).
        if ((timer >= MIN_END) && others && (!bus.S[last] || (timer >= MAX_END))) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (timer == YEL_END) begin
          state_nxt = ALL_RED;
        end
      end
      default: state_nxt = ALL_RED;
    endcase
  end

  // Request latch: sensors set requests except for the green approach; the grant clears the winner.
  always_comb begin
    wait_nxt = wait_q | (bus.S & ~((state == GREEN) ? cur_onehot : '0));
    if (grant) begin
      wait_nxt = wait_nxt & ~(N_APPR'(1) << pick);
    end
  end

  // Lamp values for the phase being entered, so the lamp registers track the state register.
  always_comb begin
    g_nxt = '0;
    y_nxt = '0;
    if (state_nxt == GREEN)  g_nxt = nxt_onehot;
    if (state_nxt == YELLOW) y_nxt = nxt_onehot;
  end

  // State, timer, request and lamp registers; reset forces all-red from any phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ALL_RED;
      timer  <= '0;
      wait_q <= '0;
      last   <= AW'(N_APPR - 1);
      r_q    <= '1;
      y_q    <= '0;
      g_q    <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wait_q <= wait_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + TW'(1);
      end
      r_q <= ~(g_nxt | y_nxt);
      y_q <= y_nxt;
      g_q <= g_nxt;
    end
  end

  assign bus.R          = r_q;
  assign bus.Y          = y_q;
  assign bus.G          = g_q;
  assign bus.active_idx = last;
  assign bus.phase      = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with N=4, MIN=4, MAX=10, YELLOW=2, ALLRED=1, REST=0.
// A table of per-cycle vectors drives sensors/reset and checks all lamps every sampled cycle,
// followed by hand-written sequences for reset-during-yellow and request clearing on grant.
module tb_traffic_phase_scheduler;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  traffic_phase_scheduler_if #(.N_APPR(4)) bus ();

  traffic_phase_scheduler #(
    .N_APPR(4), .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_T(2), .ALLRED_T(1), .REST_APPR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] s;
    int         n;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] ph;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic [3:0] s, input int n,
                     input logic [3:0] g, input logic [3:0] y,
                     input logic [1:0] ph, input logic [1:0] idx);
    vec_t v;
    v.rst = rst; v.s = s; v.n = n; v.g = g; v.y = y; v.ph = ph; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every approach shows exactly one lamp, and at most one approach is not red.
  task automatic check_inv(input string name);
    logic ok;
    int   nonred;
    ok = 1'b1;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if ((32'(bus.R[i]) + 32'(bus.Y[i]) + 32'(bus.G[i])) != 1) ok = 1'b0;
      if (bus.Y[i] | bus.G[i]) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget, input string name);
    int i;
    i = 0;
    while (bus.phase !== p && i < budget) begin
      step();
      i++;
    end
    check(name, 32'(bus.phase), 32'(p));
  endtask

  task automatic wait_green(input logic [3:0] g, input int budget, input string name);
    int i;
    i = 0;
    while (bus.G !== g && i < budget) begin
      step();
      i++;
    end
    check(name, 32'(bus.G), 32'(g));
  endtask

  initial begin
    reset = 1'b1;
    bus.S = 4'b0000;

    // reset, then rest on approach 0 with no demand
    add(1, 4'b0000,  2, 4'b0000, 4'b0000, 2'd0, 2'd3);
    add(0, 4'b0000,  1, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b0000, 50, 4'b0001, 4'b0000, 2'd1, 2'd0);
    // one-cycle pulse on S[2] while 0 rests on a saturated timer -> gap-out, serve 2
    add(0, 4'b0100,  1, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b0000,  2, 4'b0000, 4'b0001, 2'd2, 2'd0);
    add(0, 4'b0000,  1, 4'b0000, 4'b0000, 2'd0, 2'd0);
    add(0, 4'b0000,  6, 4'b0100, 4'b0000, 2'd1, 2'd2);
    // S[1] and S[3] held: min green on 0, then 1, 3, 1 each extended to max green
    add(1, 4'b0000,  2, 4'b0000, 4'b0000, 2'd0, 2'd3);
    add(0, 4'b0000,  1, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b1010,  3, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b1010,  2, 4'b0000, 4'b0001, 2'd2, 2'd0);
    add(0, 4'b1010,  1, 4'b0000, 4'b0000, 2'd0, 2'd0);
    add(0, 4'b1010, 10, 4'b0010, 4'b0000, 2'd1, 2'd1);
    add(0, 4'b1010,  2, 4'b0000, 4'b0010, 2'd2, 2'd1);
    add(0, 4'b1010,  1, 4'b0000, 4'b0000, 2'd0, 2'd1);
    add(0, 4'b1010, 10, 4'b1000, 4'b0000, 2'd1, 2'd3);
    add(0, 4'b1010,  2, 4'b0000, 4'b1000, 2'd2, 2'd3);
    add(0, 4'b1010,  1, 4'b0000, 4'b0000, 2'd0, 2'd3);
    add(0, 4'b1010,  3, 4'b0010, 4'b0000, 2'd1, 2'd1);
    // green 1 with S[1] held and S[0] waiting: exactly 10 cycles, then grant 0
    add(1, 4'b0000,  2, 4'b0000, 4'b0000, 2'd0, 2'd3);
    add(0, 4'b0010,  1, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b0010,  3, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b0010,  2, 4'b0000, 4'b0001, 2'd2, 2'd0);
    add(0, 4'b0010,  1, 4'b0000, 4'b0000, 2'd0, 2'd0);
    add(0, 4'b0010,  1, 4'b0010, 4'b0000, 2'd1, 2'd1);
    add(0, 4'b0011,  9, 4'b0010, 4'b0000, 2'd1, 2'd1);
    add(0, 4'b0011,  2, 4'b0000, 4'b0010, 2'd2, 2'd1);
    add(0, 4'b0011,  1, 4'b0000, 4'b0000, 2'd0, 2'd1);
    add(0, 4'b0011,  3, 4'b0001, 4'b0000, 2'd1, 2'd0);
    // S[3] arrives in cycle 1 of a gapped green 0: green lasts exactly MIN_GREEN
    add(1, 4'b0000,  2, 4'b0000, 4'b0000, 2'd0, 2'd3);
    add(0, 4'b0000,  1, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b1000,  3, 4'b0001, 4'b0000, 2'd1, 2'd0);
    add(0, 4'b0000,  2, 4'b0000, 4'b0001, 2'd2, 2'd0);
    add(0, 4'b0000,  1, 4'b0000, 4'b0000, 2'd0, 2'd0);
    add(0, 4'b0000,  1, 4'b1000, 4'b0000, 2'd1, 2'd3);

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      bus.S = vecs[k].s;
      for (int c = 0; c < vecs[k].n; c++) begin
        logic [15:0] exp;
        exp = {~(vecs[k].g | vecs[k].y), vecs[k].y, vecs[k].g, vecs[k].ph, vecs[k].idx};
        step();
        check($sformatf("vec%0d_cyc%0d", k, c),
              32'({bus.R, bus.Y, bus.G, bus.phase, bus.active_idx}), 32'(exp));
        check_inv($sformatf("inv_vec%0d_cyc%0d", k, c));
      end
    end

    // reset asserted in the middle of yellow
    reset = 1'b1; bus.S = 4'b0000;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_yel_green0", 32'(bus.G), 32'h1);
    bus.S = 4'b0100;
    step();
    bus.S = 4'b0000;
    wait_phase(2'd2, 20, "rst_yel_reach_yellow");
    check("rst_yel_y_lamp", 32'(bus.Y), 32'h1);
    check("rst_yel_wait_before", 32'(dut.wait_q), 32'h4);
    reset = 1'b1;
    step();
    check("rst_yel_r", 32'(bus.R), 32'hf);
    check("rst_yel_phase", 32'(bus.phase), 32'd0);
    check("rst_yel_idx", 32'(bus.active_idx), 32'd3);
    check("rst_yel_wait", 32'(dut.wait_q), 32'h0);

    // a one-cycle request is remembered and cleared when served
    reset = 1'b0;
    step();
    check("clr_green0", 32'(bus.G), 32'h1);
    bus.S = 4'b0100;
    step();
    bus.S = 4'b0000;
    wait_green(4'b0100, 20, "clr_reach_green2");
    check("clr_idx", 32'(bus.active_idx), 32'd2);
    check("clr_wait", 32'(dut.wait_q), 32'h0);
    check_inv("clr_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
